// File: rtl/frame_rd_sched_if.sv
// Handshake and status bundle between the frame read scheduler and its
// environment: frame control in, read commands and completions, status out.
interface frame_rd_sched_if;
  logic        start;
  logic        soft_reset;
  logic [31:0] frame_size;
  logic [31:0] base_addr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [12:0] cmd_len;
  logic        cpl_valid;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  start, soft_reset, frame_size, base_addr, cmd_ready, cpl_valid,
    output cmd_valid, cmd_addr, cmd_len, busy, done, err
  );

  modport slave (
    output start, soft_reset, frame_size, base_addr, cmd_ready, cpl_valid,
    input  cmd_valid, cmd_addr, cmd_len, busy, done, err
  );
endinterface

// File: rtl/frame_rd_sched.sv
// Splits a frame into word-aligned read commands of up to MAX_BURST bytes,
// keeping at most MAX_OUTST uncompleted. Optional macro FRAME_RD_SCHED_4K_SPLIT_EN.
module frame_rd_sched #(
  parameter int unsigned MAX_BURST = 256,
  parameter int unsigned MAX_OUTST = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  frame_rd_sched_if.master bus
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CALC     = 3'd1;
  localparam logic [2:0] ISSUE    = 3'd2;
  localparam logic [2:0] WAIT_CPL = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rem_q, rem_d;
  logic [12:0] len_q, len_d;
  logic [3:0]  outst_q, outst_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        hs;
  logic        cpl_ok;
  logic        cpl_stray;
  logic [12:0] len_calc;
  logic        unused_low_bits;

  // Byte-offset bits of the size and address are don't-care: everything is in words.
  assign unused_low_bits = ^{bus.frame_size[1:0], bus.base_addr[1:0]};

  function automatic logic [12:0] clamp_burst(input logic [31:0] rem);
    if (rem < 32'(MAX_BURST)) return rem[12:0];
    return 13'(MAX_BURST);
  endfunction

  assign hs        = (state_q == ISSUE) && bus.cmd_ready;
  assign cpl_ok    = bus.cpl_valid && (outst_q != 4'd0);
  assign cpl_stray = bus.cpl_valid && (outst_q == 4'd0);

  always_comb begin
    len_calc = clamp_burst(rem_q);
`ifdef FRAME_RD_SCHED_4K_SPLIT_EN
    begin
      logic [12:0] room;
      room = 13'd4096 - {1'b0, addr_q[11:0]};
      if (len_calc > room) len_calc = room;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    len_d   = len_q;
    busy_d  = busy_q;
    err_d   = err_q;
    done_d  = 1'b0;
    outst_d = outst_q + 4'(hs) - 4'(cpl_ok);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          addr_d  = {bus.base_addr[31:2], 2'b00};
          rem_d   = {bus.frame_size[31:2], 2'b00};
          busy_d  = 1'b1;
          err_d   = 1'b0;
          state_d = (bus.frame_size[31:2] == 30'd0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (outst_q != 4'(MAX_OUTST)) begin
          len_d   = len_calc;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (hs) begin
          addr_d  = addr_q + {19'd0, len_q};
          rem_d   = rem_q - {19'd0, len_q};
          state_d = (rem_q == {19'd0, len_q}) ? WAIT_CPL : CALC;
        end
      end
      WAIT_CPL: begin
        if (outst_d == 4'd0) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A stray completion wins over the clear from a start in the same cycle.
    if (cpl_stray) err_d = 1'b1;

    if (bus.soft_reset) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      outst_d = 4'd0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      rem_q   <= 32'd0;
      len_q   <= 13'd0;
      outst_q <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      outst_q <= outst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.cmd_valid = (state_q == ISSUE);
  assign bus.cmd_addr  = addr_q;
  assign bus.cmd_len   = len_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: doc/frame_rd_sched.md
FRAME_RD_SCHED -- requirements
Module: frame_rd_sched

Interface
REQ-001 The block SHALL have parameter MAX_BURST, default 256, giving the maximum bytes per command; legal values are powers of two from 4 to 4096.
REQ-002 The block SHALL have parameter MAX_OUTST, default 8, giving the maximum outstanding commands; legal range is 1 to 15.
REQ-003 Reset is aresetn, asynchronous, active-low; clock is aclk.
REQ-004 aclk  in  1  system clock.
REQ-005 aresetn  in  1  asynchronous active-low reset.
REQ-006 start  in  1  single-cycle frame start request.
REQ-007 soft_reset  in  1  synchronous abort, driven from control register bit 0.
REQ-008 frame_size  in  32  frame length in bytes; bits [1:0] are ignored.
REQ-009 base_addr  in  32  frame start byte address; bits [1:0] are ignored.
REQ-010 cmd_valid  out  1  read command valid.
REQ-011 cmd_ready  in  1  read command accepted.
REQ-012 cmd_addr  out  32  command byte address, word aligned.
REQ-013 cmd_len  out  13  command length in bytes, a nonzero multiple of 4.
REQ-014 cpl_valid  in  1  one-cycle pulse per completed command.
REQ-015 busy  out  1  high from an accepted start until done.
REQ-016 done  out  1  one-cycle frame-complete pulse.
REQ-017 err  out  1  sticky unexpected-completion flag.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, CALC, ISSUE, WAIT_CPL and DONE.
REQ-019 In IDLE, start SHALL latch base_addr and frame_size (words only) and set busy on the next cycle; err SHALL clear on the same start.
REQ-020 A start SHALL go from IDLE to DONE when the latched size is 0, and from IDLE to CALC otherwise.
REQ-021 start SHALL be ignored in every state other than IDLE.
REQ-022 CALC SHALL set len = min(remaining, MAX_BURST), further limited per REQ-036, and then go to ISSUE.
REQ-023 CALC SHALL stall while outstanding == MAX_OUTST.
REQ-024 In ISSUE, cmd_valid SHALL be 1, and cmd_addr and cmd_len SHALL stay stable until the cycle cmd_valid && cmd_ready is true.
REQ-025 On a command handshake, addr SHALL increase by len modulo 2^32, remaining SHALL decrease by len, and outstanding SHALL increase by 1.
REQ-026 After a command handshake, the FSM SHALL go to WAIT_CPL when remaining == 0, and to CALC otherwise.
REQ-027 Each cpl_valid SHALL decrement outstanding in any non-IDLE state.
REQ-028 A handshake and cpl_valid in the same cycle SHALL leave outstanding unchanged.
REQ-029 cpl_valid with outstanding == 0 SHALL be ignored and SHALL set err.
REQ-030 WAIT_CPL SHALL go to DONE when outstanding == 0, counting a completion arriving in that cycle.
REQ-031 DONE SHALL assert done for exactly one cycle, clear busy, and return to IDLE.
REQ-032 From a start with size 0, done SHALL assert 2 cycles after start.
REQ-033 soft_reset in any state SHALL, on the next cycle, force the FSM to IDLE, drop cmd_valid and busy, and clear outstanding, without asserting done.
REQ-034 soft_reset SHALL take priority over start in the same cycle.

Reset
REQ-035 While aresetn is low, the FSM SHALL be IDLE and all outputs SHALL be 0: cmd_valid, cmd_addr, cmd_len, busy, done and err; the internal counters SHALL also be 0.

Configuration
REQ-036 With FRAME_RD_SCHED_4K_SPLIT_EN defined, len SHALL also be capped at 4096 - addr[11:0], so no command crosses a 4 KB boundary. Without FRAME_RD_SCHED_4K_SPLIT_EN, no boundary cap SHALL apply and that logic SHALL be absent.

Verification
REQ-037 The bench SHALL check: base 0x1000, size 0x300, ready tied high, completions returned -> commands (0x1000,256), (0x1100,256), (0x1200,256), then one done pulse.
REQ-038 The bench SHALL check, with the macro on: base 0x1F80, size 0x100 -> commands (0x1F80,128) and (0x2000,128). With the macro off, the same stimulus SHALL give one command (0x1F80,256).
REQ-039 The bench SHALL check: size 0 -> no commands and done 2 cycles after start. Size 3 SHALL behave identically.
REQ-040 The bench SHALL check: cmd_ready held low for 5 cycles -> cmd_addr and cmd_len stable, and a second start ignored.
REQ-041 The bench SHALL check: completions withheld with MAX_OUTST=8 and size 4 KB -> exactly 8 commands issued, then a stall.
REQ-042 The bench SHALL check that soft_reset mid-frame produces cmd_valid low and busy low the next cycle, and no done pulse.
REQ-043 The bench SHALL check that a stray cpl_valid with outstanding 0 sets err, and that err stays set until the next accepted start.
